rca_wb_drain: RTL and testbench

Writeback drain stage directly downstream of the RCA execution unit. It accepts one RCA result bundle per handshake: an instruction id, `NUM_WRITE_PORTS` result words, and per-port destination register addresses with enables. It serialises the valid writes onto the single register-file write port, one per cycle, honouring a register-file stall. After the last write retires, it pulses a completion with the instruction id so the issue logic can release the id.

---
 rtl/rca_wb_drain_pkg.sv | 14 +
 rtl/rca_wb_prio_enc.sv | 17 +
 rtl/rca_wb_drain.sv | 99 +++++++++
 tb/tb_rca_wb_drain.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rca_wb_drain_pkg.sv
// rca_wb_drain_pkg: shared RCA writeback constants, drain FSM states and result bundle type
package rca_wb_drain_pkg;
  localparam int NUM_WRITE_PORTS = 5;
  localparam int XLEN = 32;
  localparam int ID_W = 3;
  localparam int RADDR_W = 5;
  typedef enum logic [1:0] {IDLE, DRAIN, DONE} rca_wb_drain_state_t;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [NUM_WRITE_PORTS-1:0][XLEN-1:0] rd;
    logic [NUM_WRITE_PORTS-1:0][RADDR_W-1:0] addr;
    logic [NUM_WRITE_PORTS-1:0] en;
  } rca_wb_bundle_t;
endpackage

// File: rtl/rca_wb_prio_enc.sv
// rca_wb_prio_enc: lowest-set-bit priority encoder
// Ports: req (request vector), idx (lowest set index, 0 when none), any (some bit set)
module rca_wb_prio_enc #(
  parameter int W = 5,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--)
      if (req[i]) idx = IW'(i);
    any = |req;
  end
endmodule

// File: rtl/rca_wb_drain.sv
// rca_wb_drain: serialises an RCA result bundle onto the single register-file write port
// Ports: clk/rst (async active-low); in_* bundle handshake; flush discards held bundle;
//        rf_stall/rf_we/rf_waddr/rf_wdata register-file port; done_valid/done_id completion; busy
module rca_wb_drain
  import rca_wb_drain_pkg::*;
#(
  parameter int NUM_WRITE_PORTS = rca_wb_drain_pkg::NUM_WRITE_PORTS,
  parameter int XLEN = rca_wb_drain_pkg::XLEN,
  parameter int ID_W = rca_wb_drain_pkg::ID_W,
  parameter int RADDR_W = rca_wb_drain_pkg::RADDR_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [ID_W-1:0]                    in_id,
  input  logic [NUM_WRITE_PORTS*XLEN-1:0]    in_rd,
  input  logic [NUM_WRITE_PORTS*RADDR_W-1:0] in_dest_addr,
  input  logic [NUM_WRITE_PORTS-1:0]         in_dest_en,
  input  logic                               flush,
  input  logic                               rf_stall,
  output logic                               rf_we,
  output logic [RADDR_W-1:0]                 rf_waddr,
  output logic [XLEN-1:0]                    rf_wdata,
  output logic                               done_valid,
  output logic [ID_W-1:0]                    done_id,
  output logic                               busy
);
  localparam int IW = (NUM_WRITE_PORTS > 1) ? $clog2(NUM_WRITE_PORTS) : 1;
  rca_wb_drain_state_t state, state_n;
  logic [NUM_WRITE_PORTS-1:0] mask, mask_n, cap_mask, rest;
  logic [ID_W-1:0] id_q;
  logic [NUM_WRITE_PORTS-1:0][XLEN-1:0] rd_q;
  logic [NUM_WRITE_PORTS-1:0][RADDR_W-1:0] addr_q;
  logic [IW-1:0] sel;
  logic any;
  logic capture;

  rca_wb_prio_enc #(.W(NUM_WRITE_PORTS), .IW(IW)) u_enc (.req(mask), .idx(sel), .any(any));

  // Writes to x0 are architecturally discarded, so they never enter the mask.
  always_comb begin
    cap_mask = '0;
    for (int i = 0; i < NUM_WRITE_PORTS; i++)
      cap_mask[i] = in_dest_en[i] && (in_dest_addr[i*RADDR_W +: RADDR_W] != '0);
  end

  assign capture = (state == IDLE) && in_valid && !flush;
  assign rest = mask & ~(NUM_WRITE_PORTS'(1) << sel);

  always_comb begin
    state_n = state;
    mask_n = mask;
    if (flush) begin
      state_n = IDLE;
      mask_n = '0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        state_n = (cap_mask != '0) ? DRAIN : DONE;
        mask_n = cap_mask;
      end
    end else if (state == DRAIN) begin
      if (!rf_stall) begin
        mask_n = rest;
        state_n = (rest == '0) ? DONE : DRAIN;
      end
    end else begin
      state_n = IDLE;
      mask_n = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      mask <= '0;
      id_q <= '0;
    end else begin
      state <= state_n;
      mask <= mask_n;
      if (capture) id_q <= in_id;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      rd_q <= in_rd;
      addr_q <= in_dest_addr;
    end
  end

  assign in_ready = (state == IDLE);
  assign busy = (state != IDLE);
  assign rf_we = (state == DRAIN) && any;
  assign rf_waddr = rf_we ? addr_q[sel] : '0;
  assign rf_wdata = rf_we ? rd_q[sel] : '0;
  assign done_valid = (state == DONE);
  assign done_id = done_valid ? id_q : '0;
endmodule

// File: tb/tb_rca_wb_drain.sv
// tb_rca_wb_drain: directed self-checking bench for rca_wb_drain
module tb_rca_wb_drain;
  import rca_wb_drain_pkg::*;
  logic clk = 0;
  logic rst = 0;
  logic in_valid = 0;
  logic in_ready;
  logic [ID_W-1:0] in_id = '0;
  logic [NUM_WRITE_PORTS*XLEN-1:0] in_rd = '0;
  logic [NUM_WRITE_PORTS*RADDR_W-1:0] in_dest_addr = '0;
  logic [NUM_WRITE_PORTS-1:0] in_dest_en = '0;
  logic flush = 0;
  logic rf_stall = 0;
  logic rf_we;
  logic [RADDR_W-1:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic done_valid;
  logic [ID_W-1:0] done_id;
  logic busy;
  int checks = 0;
  int errors = 0;
  rca_wb_bundle_t b;

  rca_wb_drain dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
    .in_rd(in_rd), .in_dest_addr(in_dest_addr), .in_dest_en(in_dest_en), .flush(flush),
    .rf_stall(rf_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .done_valid(done_valid), .done_id(done_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [ID_W-1:0] id);
    in_valid = 1;
    in_id = id;
    in_rd = b.rd;
    in_dest_addr = b.addr;
    in_dest_en = b.en;
    chk("ready_at_capture", in_ready, 1);
    step();
    in_valid = 0;
  endtask

  task automatic exp_write(input string tag, input logic [RADDR_W-1:0] a, input logic [XLEN-1:0] d);
    chk({tag, "_we"}, rf_we, 1);
    chk({tag, "_addr"}, rf_waddr, a);
    chk({tag, "_data"}, rf_wdata, d);
    chk({tag, "_nodone"}, done_valid, 0);
    chk({tag, "_ready"}, in_ready, 0);
  endtask

  task automatic exp_done(input string tag, input logic [ID_W-1:0] id);
    chk({tag, "_done"}, done_valid, 1);
    chk({tag, "_id"}, done_id, id);
    chk({tag, "_nowe"}, rf_we, 0);
    chk({tag, "_waddr0"}, rf_waddr, 0);
  endtask

  task automatic exp_idle(input string tag);
    chk({tag, "_we"}, rf_we, 0);
    chk({tag, "_done"}, done_valid, 0);
    chk({tag, "_ready"}, in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #2;
    chk("rst_ready", in_ready, 1);
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_done", done_valid, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_busy", busy, 0);
    step();
    rst = 1;
    step();
    b = '0;
    b.en = 5'b10101;
    b.addr[0] = 5; b.addr[2] = 6; b.addr[4] = 7; b.addr[1] = 3;
    b.rd[0] = 'hA; b.rd[2] = 'hB; b.rd[4] = 'hC; b.rd[1] = 'hDEAD;
    send(5);
    chk("a_busy", busy, 1);
    exp_write("a_w0", 5, 'hA);
    step();
    exp_write("a_w1", 6, 'hB);
    step();
    exp_write("a_w2", 7, 'hC);
    step();
    exp_done("a", 5);
    chk("a_done_ready", in_ready, 0);
    step();
    exp_idle("a_after");
    b = '0;
    b.addr[0] = 4; b.rd[0] = 'h77;
    send(3);
    exp_done("z", 3);
    chk("z_ready_low", in_ready, 0);
    step();
    exp_idle("z_after");
    b = '0;
    b.en = 5'b01010;
    b.addr[1] = 0; b.addr[3] = 9;
    b.rd[1] = 'h11; b.rd[3] = 'h99;
    send(1);
    exp_write("x0_w", 9, 'h99);
    step();
    exp_done("x0", 1);
    step();
    exp_idle("x0_after");
    b = '0;
    b.en = 5'b00011;
    b.addr[0] = 1; b.addr[1] = 2;
    b.rd[0] = 'h100; b.rd[1] = 'h200;
    send(6);
    rf_stall = 1;
    exp_write("st_n1", 1, 'h100);
    step();
    exp_write("st_n2", 1, 'h100);
    step();
    rf_stall = 0;
    exp_write("st_n3", 1, 'h100);
    step();
    exp_write("st_n4", 2, 'h200);
    step();
    exp_done("st", 6);
    step();
    exp_idle("st_after");
    b = '0;
    b.en = 5'b00101;
    b.addr[0] = 4; b.addr[2] = 4;
    b.rd[0] = 'h1; b.rd[2] = 'h3;
    send(2);
    exp_write("dup_w0", 4, 'h1);
    step();
    exp_write("dup_w1", 4, 'h3);
    step();
    exp_done("dup", 2);
    step();
    b = '0;
    b.en = 5'b01111;
    b.addr[0] = 1; b.addr[1] = 2; b.addr[2] = 3; b.addr[3] = 4;
    b.rd[0] = 'h10; b.rd[1] = 'h20; b.rd[2] = 'h30; b.rd[3] = 'h40;
    send(4);
    exp_write("fl_w0", 1, 'h10);
    step();
    exp_write("fl_w1", 2, 'h20);
    flush = 1;
    step();
    flush = 0;
    for (int i = 0; i < 3; i++) begin
      exp_idle("fl_after");
      step();
    end
    in_valid = 1;
    flush = 1;
    in_id = 7;
    step();
    in_valid = 0;
    flush = 0;
    for (int i = 0; i < 2; i++) begin
      exp_idle("flcap");
      step();
    end
    b = '0;
    b.en = 5'b00111;
    b.addr[0] = 8; b.addr[1] = 9; b.addr[2] = 10;
    b.rd[0] = 'h5; b.rd[1] = 'h6; b.rd[2] = 'h7;
    send(5);
    exp_write("rs_w0", 8, 'h5);
    #2;
    rst = 0;
    #1;
    chk("rs_async_we", rf_we, 0);
    chk("rs_async_busy", busy, 0);
    chk("rs_async_waddr", rf_waddr, 0);
    @(posedge clk);
    #1;
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      exp_idle("rs_after");
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
